instr_exec: RTL and testbench
=============================

Name: instr_exec

Overview:
Accumulator-based executor that consumes the 4-bit instruction words produced by the instruction RAM / program-counter stage and carries them out.
- Sits directly downstream of the instruction-fetch path.
- Accepts one instruction per valid/ready handshake.
- Updates an accumulator and flags.
- Publishes the accumulator on an output register with a strobe.
- Has a multi-cycle multiply and a sticky halt.

Parameters:
W, 4, accumulator / output data width in bits (legal range 2..16).

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  reset, synchronous, active-high
instr  input  4  instruction word; [3:2] opcode, [1:0] immediate
instr_valid  input  1  instr is valid this cycle
instr_ready  output  1  executor can accept an instruction this cycle
acc  output  W  accumulator value
carry  output  1  carry/overflow flag
zero  output  1  combinational, high when acc == 0
out_data  output  W  last value written by OUT
out_valid  output  1  one-cycle pulse when out_data updates
halted  output  1  executor stopped by HALT

Behaviour:
- Reset values (rst high at an edge, wins over everything):
  - state = IDLE; acc = 0; carry = 0; out_data = 0; out_valid = 0; halted = 0.
  - Multiply registers mul_m = 0 and mul_cnt = 0.
  - Reset mid-multiply abandons the multiply with no partial result.
- Handshake:
  - An instruction is accepted on an edge where instr_valid && instr_ready.
  - instr_ready = (state == IDLE); it is low in MUL and HALT.
  - No buffering: instr_valid while ready is low is ignored, and upstream must hold the instruction.
- Opcodes (imm = zero-extended instr[1:0]):
  - 00 LDI: acc <= imm; carry <= 0. Takes 1 cycle.
  - 01 ADDI: {carry, acc} <= acc + imm (W+1 bit sum); wrap mod 2^W. Takes 1 cycle.
  - 10 MUL: acc <= (acc * imm) mod 2^W; carry = 1 if any partial sum overflowed W bits, otherwise 0.
    - imm == 0: acc <= 0 and carry <= 0 in the accept cycle; state stays IDLE.
    - imm >= 1, accept edge T: mul_m <= acc; mul_cnt <= imm; acc <= 0; carry <= 0; state <= MUL.
    - Each MUL edge: {c, acc} <= acc + mul_m; carry <= carry | c; mul_cnt <= mul_cnt - 1.
    - On the MUL edge where mul_cnt == 1, state <= IDLE.
    - Result: ready is low for imm cycles and high again after edge T+imm, so the next instruction can be accepted at edge T+imm+1.
  - 1100 NOP: no state change.
  - 1101 CLR: acc <= 0; carry <= 0.
  - 1110 OUT: out_data <= acc, and out_valid is 1 for exactly the following cycle.
    - Back-to-back OUTs give consecutive out_valid pulses.
  - 1111 HALT: state <= HALT; halted <= 1.
    - Sticky until rst.
    - acc, flags and out_data are frozen.
- FSM:
  - IDLE -> MUL on MUL with imm != 0.
  - IDLE -> HALT on HALT.
  - MUL -> IDLE when mul_cnt == 1.
  - HALT -> HALT.
- Outputs other than out_valid and zero hold their value between updates.
- out_valid is 0 in every cycle not directly following an OUT accept.

Decomposition:
- Package instr_exec_pkg holds:
  - opcode constants (OP_LDI, OP_ADDI, OP_MUL, OP_CTL);
  - control sub-codes (CTL_NOP, CTL_CLR, CTL_OUT, CTL_HALT);
  - state enum {IDLE, MUL, HALT}.
- Single module; no sub-module is natural. The multiply sequencer is a few registers inside the FSM.

Test Plan:
- rst 1 cycle, then LDI 3 (0011), ADDI 3 (0111) -> acc = 6, carry = 0, zero = 0, ready high every cycle.
- acc = 6, MUL 3 (1011) -> ready low 3 cycles; acc sequence 0, 6, 12, 2 (18 mod 16); carry = 1; ready high after the 3rd MUL edge.
- LDI 2, MUL 0 (1000) -> acc = 0, zero = 1, carry = 0, ready never drops.
- LDI 1, OUT (1110), OUT -> out_data = 1 with out_valid high for two consecutive cycles, then 0. CLR -> acc = 0, out_data still 1.
- HALT (1111), then LDI 3 held valid for 5 cycles -> halted = 1, ready = 0, acc unchanged; rst -> all outputs 0, ready = 1.
- LDI 3, MUL 3, assert rst on the 2nd MUL cycle -> next cycle state IDLE, acc = 0, carry = 0, ready = 1; ADDI 1 then gives acc = 1.

Source files
------------

// File: rtl/instr_exec_pkg.sv
// ---------------------------------------------------------------------------
// instr_exec_pkg
// Shared definitions for the accumulator executor:
//   - 2-bit opcode field values (instr[3:2])
//   - control sub-codes used when the opcode is OP_CTL (instr[1:0])
//   - executor state enumeration
// ---------------------------------------------------------------------------
package instr_exec_pkg;

    // Opcode field, instr[3:2]
    localparam logic [1:0] OP_LDI  = 2'b00;
    localparam logic [1:0] OP_ADDI = 2'b01;
    localparam logic [1:0] OP_MUL  = 2'b10;
    localparam logic [1:0] OP_CTL  = 2'b11;

    // Control sub-codes, instr[1:0] when opcode == OP_CTL
    localparam logic [1:0] CTL_NOP  = 2'b00;
    localparam logic [1:0] CTL_CLR  = 2'b01;
    localparam logic [1:0] CTL_OUT  = 2'b10;
    localparam logic [1:0] CTL_HALT = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        HALT = 2'b10
    } state_t;

endpackage

// File: rtl/instr_exec.sv
// ---------------------------------------------------------------------------
// instr_exec
// Accumulator-based executor for 4-bit instruction words. One instruction is
// accepted per valid/ready handshake while idle. MUL with a non-zero
// immediate runs as repeated addition over imm cycles with ready held low.
// HALT stops the executor until reset.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   instr[3:0]   instruction word: [3:2] opcode, [1:0] immediate
//   instr_valid  instr is valid this cycle
//   instr_ready  executor can accept an instruction (state == IDLE)
//   acc[W-1:0]   accumulator
//   carry        carry / multiply overflow flag
//   zero         combinational, acc == 0
//   out_data     last value written by OUT
//   out_valid    one-cycle pulse after each OUT accept
//   halted       sticky halt indicator
// ---------------------------------------------------------------------------
module instr_exec
    import instr_exec_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   instr,
    input  logic         instr_valid,
    output logic         instr_ready,
    output logic [W-1:0] acc,
    output logic         carry,
    output logic         zero,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    output logic         halted
);

    state_t       r_state;
    logic [W-1:0] r_acc;
    logic         r_carry;
    logic [W-1:0] r_out_data;
    logic         r_out_valid;
    logic         r_halted;
    logic [W-1:0] r_mul_m;
    logic [1:0]   r_mul_cnt;

    logic [1:0]   w_opcode;
    logic [1:0]   w_imm2;
    logic [W-1:0] w_imm;
    logic [W:0]   w_add_sum;
    logic [W:0]   w_mul_sum;

    assign w_opcode  = instr[3:2];
    assign w_imm2    = instr[1:0];
    assign w_imm     = W'(w_imm2);
    // W+1 bit sums: the top bit is the carry out of the W-bit accumulator.
    assign w_add_sum = {1'b0, r_acc} + {1'b0, w_imm};
    assign w_mul_sum = {1'b0, r_acc} + {1'b0, r_mul_m};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_carry     <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_halted    <= 1'b0;
            r_mul_m     <= '0;
            r_mul_cnt   <= '0;
        end else begin
            // out_valid only ever lasts the single cycle after an OUT accept.
            r_out_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (instr_valid) begin
                        case (w_opcode)
                            OP_LDI: begin
                                r_acc   <= w_imm;
                                r_carry <= 1'b0;
                            end
                            OP_ADDI: begin
                                r_acc   <= w_add_sum[W-1:0];
                                r_carry <= w_add_sum[W];
                            end
                            OP_MUL: begin
                                // The product is rebuilt from zero by adding the
                                // old accumulator imm times; imm == 0 finishes here.
                                r_acc   <= '0;
                                r_carry <= 1'b0;
                                if (w_imm2 != 2'b00) begin
                                    r_mul_m   <= r_acc;
                                    r_mul_cnt <= w_imm2;
                                    r_state   <= MUL;
                                end
                            end
                            default: begin
                                case (w_imm2)
                                    CTL_CLR: begin
                                        r_acc   <= '0;
                                        r_carry <= 1'b0;
                                    end
                                    CTL_OUT: begin
                                        r_out_data  <= r_acc;
                                        r_out_valid <= 1'b1;
                                    end
                                    CTL_HALT: begin
                                        r_state  <= HALT;
                                        r_halted <= 1'b1;
                                    end
                                    default: ; // CTL_NOP
                                endcase
                            end
                        endcase
                    end
                end
                MUL: begin
                    // Carry is sticky across the partial sums of one multiply.
                    r_acc     <= w_mul_sum[W-1:0];
                    r_carry   <= r_carry | w_mul_sum[W];
                    r_mul_cnt <= r_mul_cnt - 2'd1;
                    if (r_mul_cnt == 2'd1) begin
                        r_state <= IDLE;
                    end
                end
                HALT: ; // frozen until reset
                default: r_state <= IDLE;
            endcase
        end
    end

    assign instr_ready = (r_state == IDLE);
    assign acc         = r_acc;
    assign carry       = r_carry;
    assign zero        = (r_acc == '0);
    assign out_data    = r_out_data;
    assign out_valid   = r_out_valid;
    assign halted      = r_halted;

endmodule

// File: tb/tb_instr_exec.sv
// ---------------------------------------------------------------------------
// tb_instr_exec
// Self-checking bench for instr_exec (W = 4). A behavioural model tracks the
// architectural results of each instruction; a compare process checks every
// DUT output against it on each falling edge. Directed steps with literal
// expectations pin the model, followed by a randomized instruction stream.
// ---------------------------------------------------------------------------
module tb_instr_exec;

    localparam int W   = 4;
    localparam int MOD = 1 << W;

    logic         clk;
    logic         rst;
    logic [3:0]   instr;
    logic         instr_valid;
    logic         instr_ready;
    logic [W-1:0] acc;
    logic         carry;
    logic         zero;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         halted;

    int n_checks = 0;
    int n_errors = 0;

    instr_exec #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .instr      (instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .acc        (acc),
        .carry      (carry),
        .zero       (zero),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int m_acc       = 0;
    int m_carry     = 0;
    int m_out_data  = 0;
    int m_out_valid = 0;
    int m_halted    = 0;
    int m_mul_busy  = 0;   // multiply in progress
    int m_mul_base  = 0;   // accumulator value being multiplied
    int m_mul_k     = 0;   // additions completed so far
    int m_mul_n     = 0;   // immediate (total additions)
    bit model_live  = 0;   // set once the first reset has been applied

    always @(posedge clk) begin
        int op, imm, ov;
        if (rst) begin
            m_acc = 0; m_carry = 0; m_out_data = 0; m_out_valid = 0;
            m_halted = 0; m_mul_busy = 0; m_mul_k = 0;
            model_live = 1;
        end else begin
            ov = 0;
            if (m_mul_busy != 0) begin
                // After k additions the accumulator holds base*k; a partial
                // sum overflowed as soon as base*k reached 2^W.
                m_mul_k = m_mul_k + 1;
                m_acc   = (m_mul_base * m_mul_k) % MOD;
                m_carry = (m_mul_base * m_mul_k >= MOD) ? 1 : 0;
                if (m_mul_k == m_mul_n) m_mul_busy = 0;
            end else if (m_halted == 0 && instr_valid) begin
                op  = int'(instr[3:2]);
                imm = int'(instr[1:0]);
                case (op)
                    0: begin m_acc = imm; m_carry = 0; end
                    1: begin
                        m_carry = (m_acc + imm >= MOD) ? 1 : 0;
                        m_acc   = (m_acc + imm) % MOD;
                    end
                    2: begin
                        if (imm != 0) begin
                            m_mul_base = m_acc; m_mul_n = imm; m_mul_k = 0;
                            m_mul_busy = 1;
                        end
                        m_acc = 0; m_carry = 0;
                    end
                    default: begin
                        if (imm == 1) begin m_acc = 0; m_carry = 0; end
                        else if (imm == 2) begin m_out_data = m_acc; ov = 1; end
                        else if (imm == 3) m_halted = 1;
                    end
                endcase
            end
            m_out_valid = ov;
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_live && !rst) begin
            chk("cyc acc",       int'(acc),         m_acc);
            chk("cyc carry",     int'(carry),       m_carry);
            chk("cyc zero",      int'(zero),        (m_acc == 0) ? 1 : 0);
            chk("cyc out_data",  int'(out_data),    m_out_data);
            chk("cyc out_valid", int'(out_valid),   m_out_valid);
            chk("cyc halted",    int'(halted),      m_halted);
            chk("cyc ready",     int'(instr_ready),
                (m_halted == 0 && m_mul_busy == 0) ? 1 : 0);
        end
    end

    // One clock: drive inputs, let the edge sample them, return 1 time unit later.
    task automatic cyc(input logic v, input logic [3:0] ins, input logic r);
        instr_valid = v;
        instr       = ins;
        rst         = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hcnt;
        logic r, v;
        logic [3:0] ins;
        rst = 1'b1; instr_valid = 1'b0; instr = 4'h0;
        @(posedge clk); #1;

        // reset state
        cyc(1'b0, 4'h0, 1'b1);
        rst = 1'b0;
        chk("rst acc", int'(acc), 0);
        chk("rst ready", int'(instr_ready), 1);
        chk("rst halted", int'(halted), 0);
        chk("rst out_valid", int'(out_valid), 0);

        // LDI 3, ADDI 3
        cyc(1'b1, 4'b0011, 1'b0);
        chk("ldi ready", int'(instr_ready), 1);
        cyc(1'b1, 4'b0111, 1'b0);
        chk("addi acc", int'(acc), 6);
        chk("addi carry", int'(carry), 0);
        chk("addi zero", int'(zero), 0);

        // MUL 3 with acc = 6: 0, 6, 12, 2 and carry set
        cyc(1'b1, 4'b1011, 1'b0);
        chk("mul t0 acc", int'(acc), 0);
        chk("mul t0 ready", int'(instr_ready), 0);
        cyc(1'b1, 4'b0001, 1'b0); // held, ignored while busy
        chk("mul t1 acc", int'(acc), 6);
        cyc(1'b0, 4'h0, 1'b0);
        chk("mul t2 acc", int'(acc), 12);
        chk("mul t2 ready", int'(instr_ready), 0);
        cyc(1'b0, 4'h0, 1'b0);
        chk("mul t3 acc", int'(acc), 2);
        chk("mul t3 carry", int'(carry), 1);
        chk("mul t3 ready", int'(instr_ready), 1);

        // LDI 2, MUL 0
        cyc(1'b1, 4'b0010, 1'b0);
        cyc(1'b1, 4'b1000, 1'b0);
        chk("mul0 acc", int'(acc), 0);
        chk("mul0 zero", int'(zero), 1);
        chk("mul0 carry", int'(carry), 0);
        chk("mul0 ready", int'(instr_ready), 1);

        // LDI 1, OUT, OUT, idle, CLR
        cyc(1'b1, 4'b0001, 1'b0);
        cyc(1'b1, 4'b1110, 1'b0);
        chk("out1 valid", int'(out_valid), 1);
        chk("out1 data", int'(out_data), 1);
        cyc(1'b1, 4'b1110, 1'b0);
        chk("out2 valid", int'(out_valid), 1);
        cyc(1'b0, 4'h0, 1'b0);
        chk("out3 valid", int'(out_valid), 0);
        cyc(1'b1, 4'b1101, 1'b0);
        chk("clr acc", int'(acc), 0);
        chk("clr out_data", int'(out_data), 1);

        // LDI 2, HALT, then LDI 3 held for 5 cycles
        cyc(1'b1, 4'b0010, 1'b0);
        cyc(1'b1, 4'b1111, 1'b0);
        chk("halt halted", int'(halted), 1);
        chk("halt ready", int'(instr_ready), 0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 4'b0011, 1'b0);
        chk("halt acc", int'(acc), 2);
        chk("halt ready2", int'(instr_ready), 0);
        cyc(1'b0, 4'h0, 1'b1);
        chk("unhalt acc", int'(acc), 0);
        chk("unhalt out_data", int'(out_data), 0);
        chk("unhalt halted", int'(halted), 0);
        chk("unhalt ready", int'(instr_ready), 1);

        // LDI 3, MUL 3, reset on second multiply cycle, ADDI 1
        cyc(1'b1, 4'b0011, 1'b0);
        cyc(1'b1, 4'b1011, 1'b0);
        cyc(1'b0, 4'h0, 1'b0);
        chk("mulrst mid acc", int'(acc), 3);
        cyc(1'b0, 4'h0, 1'b1);
        chk("mulrst acc", int'(acc), 0);
        chk("mulrst carry", int'(carry), 0);
        chk("mulrst ready", int'(instr_ready), 1);
        cyc(1'b1, 4'b0101, 1'b0);
        chk("mulrst addi acc", int'(acc), 1);
        cyc(1'b0, 4'h0, 1'b0);
        chk("mulrst hold acc", int'(acc), 1);

        // Randomized stream, checked by the per-cycle compare process.
        hcnt = 0;
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 199) == 0) || (hcnt > 8);
            v   = ($urandom_range(0, 3) != 0);
            ins = 4'($urandom_range(0, 15));
            if (ins == 4'hF && $urandom_range(0, 3) != 0) ins = 4'hC;
            cyc(v, ins, r);
            hcnt = (halted && !r) ? hcnt + 1 : 0;
        end

        cyc(1'b0, 4'h0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
